// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
// Holds the sequencer state encoding and the lock-loss counter width.
package pll_seq_pkg;

  localparam int unsigned LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer, async active-high reset to 0.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset
//   d   - asynchronous input bit
//   q   - synchronized output (2 clk latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the reference clock domain.
// Pulses the PLL reset, waits for lock with a timeout, requires lock to be
// stable before releasing sys_rst, retries a bounded number of times and
// flags lock_fail once retries are exhausted.
// Optional: define PLLSEQ_LOSS_COUNT_EN to implement lock_loss_cnt;
// otherwise it is tied to zero.
// Ports:
//   refclk        - 50 MHz reference clock
//   rst           - asynchronous active-high reset
//   pll_locked    - PLL lock indicator (asynchronous)
//   pll_rst       - reset to the PLL, active-high
//   sys_rst       - system reset, active-high
//   lock_fail     - sticky failure flag
//   retry_cnt     - retries consumed in the current bring-up
//   lock_loss_cnt - saturating count of lock losses while running
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 4,
  parameter int unsigned CNT_W               = 17
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  lock_fail,
  output logic [2:0]            retry_cnt,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]       MAX_R    = 3'(MAX_RETRIES);

  pll_seq_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic             lk_s;

  // Bring pll_locked into the refclk domain.
  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk_s)
  );

  // Sequencer FSM; outputs are assigned alongside the state they belong to
  // so they change on the same edge as the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      lock_fail <= 1'b0;
      retry_cnt <= 3'd0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority over a timeout on the same cycle.
          if (lk_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt < MAX_R) begin
              retry_cnt <= retry_cnt + 3'd1;
              state     <= PLL_RST;
            end else begin
              state     <= FAIL;
              lock_fail <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          // A dropout restarts the lock wait without consuming a retry.
          if (!lk_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            sys_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lk_s) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            retry_cnt <= 3'd0;
          end
        end
        FAIL: begin
          pll_rst   <= 1'b1;
          sys_rst   <= 1'b1;
          lock_fail <= 1'b1;
        end
        default: begin
          state   <= PLL_RST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
        end
      endcase
    end
  end

`ifdef PLLSEQ_LOSS_COUNT_EN
  // Saturating count of lock losses observed while running.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_loss_cnt <= '0;
    end else if (state == RUN && !lk_s && lock_loss_cnt != '1) begin
      lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
    end
  end
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer with reduced timing parameters.
module tb_pll_reset_sequencer;

  localparam int unsigned P_RST = 4;
  localparam int unsigned P_TMO = 20;
  localparam int unsigned P_STB = 8;
  localparam int unsigned P_RET = 2;

`ifdef PLLSEQ_LOSS_COUNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_fail;
  logic [2:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int total;
  int bad;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_TIMEOUT_CYCLES (P_TMO),
    .LOCK_STABLE_CYCLES  (P_STB),
    .MAX_RETRIES         (P_RET),
    .CNT_W               (17)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .lock_fail     (lock_fail),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for sys_rst to reach a value; an expired budget fails the check.
  task automatic wait_sys(input string tag, input logic val, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sys_rst === val) break;
      step();
    end
    chk(tag, 32'(sys_rst), 32'(val));
  endtask

  function automatic logic [31:0] exp_loss(input int n);
    if (!LOSS_EN) return 32'd0;
    return (n > 255) ? 32'd255 : 32'(n);
  endfunction

  // Hold reset for a couple of edges, release just after an edge.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    pll_locked = 1'b0;

    // Reset state
    step(); step(); step();
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_sys_rst", 32'(sys_rst), 32'd1);
    chk("rst_lock_fail", 32'(lock_fail), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    chk("rst_loss", 32'(lock_loss_cnt), 32'd0);

    // Nominal bring-up: pll_locked rises 10 cycles after release
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("nom_pll_rst_hi", 32'(pll_rst), 32'd1);
      step();
    end
    chk("nom_pll_rst_lo", 32'(pll_rst), 32'd0);
    for (int i = 0; i < 6; i++) step();
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("nom_sys_rst_hold", 32'(sys_rst), 32'd1);
    end
    step();
    chk("nom_sys_rst_rel", 32'(sys_rst), 32'd0);
    chk("nom_retry", 32'(retry_cnt), 32'd0);
    chk("nom_lock_fail", 32'(lock_fail), 32'd0);
    chk("nom_pll_rst_run", 32'(pll_rst), 32'd0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    step();
    chk("loss_sys_e1", 32'(sys_rst), 32'd0);
    step();
    chk("loss_sys_e2", 32'(sys_rst), 32'd0);
    step();
    chk("loss_sys_e3", 32'(sys_rst), 32'd1);
    chk("loss_pll_rst_e3", 32'(pll_rst), 32'd1);
    chk("loss_cnt1", lock_loss_cnt, exp_loss(1));
    chk("loss_retry", 32'(retry_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("loss_pll_rst_hi", 32'(pll_rst), 32'd1);
    end
    step();
    chk("loss_pll_rst_lo", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("relock_sys_hold", 32'(sys_rst), 32'd1);
    end
    step();
    chk("relock_sys_rel", 32'(sys_rst), 32'd0);

    // Glitch during STABLE: 5 cycles locked, 1 low, then steady
    pll_locked = 1'b0;
    do_reset();
    chk("glitch_loss_cleared", 32'(lock_loss_cnt), 32'd0);
    for (int i = 0; i < 4; i++) step();
    pll_locked = 1'b1;
    for (int i = 0; i < 5; i++) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("glitch_sys_hold", 32'(sys_rst), 32'd1);
      chk("glitch_no_pulse", 32'(pll_rst), 32'd0);
    end
    step();
    chk("glitch_sys_rel", 32'(sys_rst), 32'd0);
    chk("glitch_retry", 32'(retry_cnt), 32'd0);

    // Async reset mid-STABLE, with pll_locked held high
    do_reset();
    for (int i = 0; i < 7; i++) step();
    chk("arst_pre_pll_rst", 32'(pll_rst), 32'd0);
    #5;
    rst = 1'b1;
    #1;
    chk("arst_pll_rst_imm", 32'(pll_rst), 32'd1);
    chk("arst_sys_rst_imm", 32'(sys_rst), 32'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("arst_restart_hi", 32'(pll_rst), 32'd1);
      step();
    end
    chk("arst_restart_lo", 32'(pll_rst), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("arst_sys_hold", 32'(sys_rst), 32'd1);
    end
    step();
    chk("arst_sys_rel", 32'(sys_rst), 32'd0);

    // Timeout and retry with pll_locked held low
    pll_locked = 1'b0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        chk("tmo_pulse_hi", 32'(pll_rst), 32'd1);
        step();
      end
      for (int i = 0; i < 20; i++) begin
        chk("tmo_gap_lo", 32'(pll_rst), 32'd0);
        chk("tmo_gap_fail", 32'(lock_fail), 32'd0);
        step();
      end
      chk("tmo_retry", 32'(retry_cnt), (p < 2) ? 32'(p + 1) : 32'd2);
      chk("tmo_fail_flag", 32'(lock_fail), (p == 2) ? 32'd1 : 32'd0);
    end
    chk("fail_pll_rst", 32'(pll_rst), 32'd1);
    chk("fail_sys_rst", 32'(sys_rst), 32'd1);
    pll_locked = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("fail_sticky", 32'(lock_fail), 32'd1);
    chk("fail_pll_rst_held", 32'(pll_rst), 32'd1);
    chk("fail_sys_rst_held", 32'(sys_rst), 32'd1);

    // Saturation: 260 lock-loss/re-lock cycles
    do_reset();
    wait_sys("sat_initial_run", 1'b0, 40);
    for (int n = 1; n <= 260; n++) begin
      pll_locked = 1'b0;
      step(); step(); step();
      pll_locked = 1'b1;
      wait_sys("sat_relock", 1'b0, 40);
      if (n == 1 || n == 254 || n == 255 || n == 256 || n == 260)
        chk("sat_loss_cnt", lock_loss_cnt, exp_loss(n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Initiator side of the PLL reset/locked interface: drives the PLL `rst` input and consumes the PLL `locked` output.
- Pulses the PLL reset, waits for lock with a timeout, and requires lock to stay stable before releasing the system reset.
- Retries a bounded number of times, then flags failure.
- Runs on the 50 MHz reference clock domain (the PLL input clock), so it keeps running while the PLL is unlocked.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per reset pulse (>=1).
- LOCK_TIMEOUT_CYCLES, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before releasing sys_rst.
- MAX_RETRIES, 4: number of PLL reset re-attempts after the first before entering FAIL.
- CNT_W, 17: width of the shared cycle counter; must hold the largest of the three cycle parameters.

Ports:
- refclk  in  1  clock, 50 MHz reference.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
- pll_rst  out  1  reset to the PLL, active-high.
- sys_rst  out  1  system reset for 100/50 MHz domains, active-high; consumers synchronize deassertion locally.
- lock_fail  out  1  sticky; high once retries are exhausted.
- retry_cnt  out  3  number of retries consumed in the current bring-up.
- lock_loss_cnt  out  8  saturating count of lock losses while in RUN (see Optional Feature).

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Clock port is `refclk`, reset port is `rst`.
- Reset values:
  - pll_rst=1, sys_rst=1, lock_fail=0, retry_cnt=0, lock_loss_cnt=0.
  - state=PLL_RST, counter=0, synchronizer flops=0.
- Synchronizer: pll_locked passes through a 2-flop synchronizer to give lk_s. Every decision below uses lk_s, so latency from pll_locked to lk_s is 2 cycles.
- FSM states: PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL.
- PLL_RST:
  - pll_rst=1, sys_rst=1.
  - Counter counts 0..PLL_RST_CYCLES-1, then goes to WAIT_LOCK with counter cleared.
  - pll_rst is high for exactly PLL_RST_CYCLES cycles after rst deasserts.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If lk_s=1, go to STABLE with counter=0.
  - Otherwise, when counter reaches LOCK_TIMEOUT_CYCLES-1:
    - if retry_cnt<MAX_RETRIES, retry_cnt++ and go to PLL_RST;
    - otherwise go to FAIL.
  - If lk_s rises on the timeout cycle itself, lock wins.
- STABLE:
  - pll_rst=0, sys_rst=1.
  - If lk_s=0, go back to WAIT_LOCK with counter=0. The timeout restarts and retry_cnt is unchanged.
  - When counter reaches LOCK_STABLE_CYCLES-1 with lk_s=1, go to RUN.
  - sys_rst deasserts on the first RUN cycle.
- RUN:
  - sys_rst=0, pll_rst=0.
  - On lk_s=0, go to PLL_RST: sys_rst=1 on the next edge, lock_loss_cnt increments (saturates at 255), retry_cnt clears to 0.
- FAIL:
  - pll_rst=1, sys_rst=1, lock_fail=1.
  - Terminal; leaves only on rst.
- Counter: a single CNT_W counter, cleared on every state transition, never wraps within a state.
- Reset mid-operation: rst asserted in any state forces all reset values asynchronously. On release the sequence restarts from PLL_RST.
- Outputs are registered; there are no combinational paths from pll_locked.

Optional Feature:
- Macro: PLLSEQ_LOSS_COUNT_EN.
- Defined: the lock_loss_cnt register is implemented as described above.
- Undefined: lock_loss_cnt is tied to 8'd0, no counter flops exist, and all other behaviour is identical.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum typedef (pll_seq_state_t: PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL);
  - the localparam LOSS_CNT_W=8.
- One sub-module, sync_2ff: a generic 2-flop bit synchronizer with async active-high reset to 0. It is reused by downstream domains for sys_rst deassertion.

Test Plan:
- Test parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up:
  - Stimulus: release rst, pll_locked rises 10 cycles later.
  - Required: pll_rst high exactly 4 cycles; sys_rst falls 2+8 cycles after pll_locked rises (plus 1 state edge); retry_cnt=0, lock_fail=0.
- Timeout and retry:
  - Stimulus: pll_locked held 0.
  - Required: 3 pll_rst pulses of 4 cycles, each separated by 20 low cycles; retry_cnt reaches 2; then FAIL with lock_fail=1 and pll_rst=1 held.
- Glitch during STABLE:
  - Stimulus: locked for 5 cycles, low for 1, then steady.
  - Required: no new pll_rst pulse; stability count restarts; sys_rst falls 8 cycles after the final lk_s rise.
- Lock loss in RUN:
  - Stimulus: pll_locked drops.
  - Required: sys_rst=1 within 3 cycles; pll_rst pulse of 4 cycles; lock_loss_cnt=1 (0 if macro undefined); re-lock returns to RUN.
- Async reset mid-STABLE:
  - Stimulus: assert rst between edges.
  - Required: pll_rst=1 and sys_rst=1 immediately, without waiting for an edge; the sequence restarts from PLL_RST.
- Saturation:
  - Stimulus: 260 lock-loss/re-lock cycles.
  - Required: lock_loss_cnt holds at 255.
